// File: rtl/dpram_fifo_pkg.sv
// rtl/dpram_fifo_pkg.sv - shared sizing constants for the dual-port RAM FIFO controller
package dpram_fifo_pkg;

  // Default geometry; the controller parameters start from these values.
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int PTR_W  = ADDR_W + 1;
  localparam int CNT_W  = ADDR_W + 1;

  // Output buffer holds at most two words; issue only while this leaves room.
  localparam int OUT_BUF_DEPTH = 2;

endpackage

// File: rtl/dpram_fifo_ctrl_if.sv
// rtl/dpram_fifo_ctrl_if.sv - valid/ready word stream used on producer and consumer sides
interface dpram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  // master drives the word, slave answers with ready
  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/fifo_out_buf.sv
// rtl/fifo_out_buf.sv - 2-entry register FIFO holding words read back from the RAM
module fifo_out_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            out_cnt,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic                  rd_idx;
  logic                  wr_idx;

  // Ping-pong slots: a push always lands in the slot not holding the head,
  // so the head word stays stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0   <= '0;
      slot1   <= '0;
      rd_idx  <= 1'b0;
      wr_idx  <= 1'b0;
      out_cnt <= 2'd0;
    end else begin
      if (push) begin
        if (wr_idx) slot1 <= push_data;
        else        slot0 <= push_data;
        wr_idx <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      case ({push, pop})
        2'b10:   out_cnt <= out_cnt + 2'd1;
        2'b01:   out_cnt <= out_cnt - 2'd1;
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  assign head = rd_idx ? slot1 : slot0;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - drives a dual-port RAM as a first-word-fall-through FIFO
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dpram_fifo_ctrl_if.slave      s,
  dpram_fifo_ctrl_if.master     m,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
);

  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;
  logic                inflight;
  logic [1:0]          out_cnt;
  logic                ram_empty;
  logic                ram_full;
  logic                push;
  logic                pop;
  logic                issue;
  logic [2:0]          occ_after_pop;

  // Pointer comparisons use the extra MSB to tell full from empty.
  assign ram_empty = (wptr == rptr);
  assign ram_full  = (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]) &&
                     (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]);

  // Producer side only looks at RAM pointers, keeping m_ready off this path.
  assign s.ready = !ram_full;
  assign push    = s.valid && !ram_full;
  assign pop     = m.valid && m.ready;

  // A read is launched only if the buffer can still take its result next cycle.
  assign occ_after_pop = {1'b0, out_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue         = !ram_empty && (occ_after_pop < 3'(OUT_BUF_DEPTH));

  assign ram_we_a   = push;
  assign ram_addr_a = wptr[ADDR_WIDTH-1:0];
  assign ram_din_a  = s.data;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rptr[ADDR_WIDTH-1:0];

  // Pointers, read-in-flight flag and occupancy; issue/capture move words
  // between stages without changing the total, so count tracks push minus pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
      count    <= '0;
    end else begin
      if (push)  wptr <= wptr + 1'b1;
      if (issue) rptr <= rptr + 1'b1;
      inflight <= issue;
      count    <= count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
    end
  end

  fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (ram_dout_b),
    .pop       (pop),
    .out_cnt   (out_cnt),
    .head      (m.data)
  );

  assign m.valid = (out_cnt != 2'd0);

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - randomized and directed bench for dpram_fifo_ctrl
module tb_dpram_fifo_ctrl;
  import dpram_fifo_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [4:0] count;
  logic       ram_we_a;
  logic [3:0] ram_addr_a;
  logic [7:0] ram_din_a;
  logic       ram_we_b;
  logic [3:0] ram_addr_b;
  logic [7:0] ram_dout_b;
  logic [7:0] ram_mem [16];

  dpram_fifo_ctrl_if #(.DATA_WIDTH(8)) s_if ();
  dpram_fifo_ctrl_if #(.DATA_WIDTH(8)) m_if ();

  dpram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (s_if),
    .m          (m_if),
    .count      (count),
    .ram_we_a   (ram_we_a),
    .ram_addr_a (ram_addr_a),
    .ram_din_a  (ram_din_a),
    .ram_we_b   (ram_we_b),
    .ram_addr_b (ram_addr_b),
    .ram_dout_b (ram_dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dual-port RAM with registered read, old data on read-during-write
  always @(posedge clk) begin
    if (ram_we_a) ram_mem[ram_addr_a] <= ram_din_a;
    ram_dout_b <= ram_mem[ram_addr_b];
  end

  int n_vec = 0;
  int n_err = 0;

  // reference model: words waiting in RAM, one read in flight, output buffer
  logic [7:0] ramq [$];
  logic [7:0] outq [$];
  int         infl = 0;
  logic [7:0] infl_word;

  logic       obs_mv;
  logic [7:0] obs_md;
  logic       obs_sr;
  logic [4:0] obs_cnt;
  logic       obs_push;
  logic [7:0] dcnt;
  int         nout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic sv, input logic [7:0] sd, input logic mr);
    logic exp_sr;
    logic exp_mv;
    logic push;
    logic pop;
    logic issue;
    @(negedge clk);
    s_if.valid = sv;
    s_if.data  = sd;
    m_if.ready = mr;
    #1;
    exp_sr = (ramq.size() < DEPTH);
    exp_mv = (outq.size() != 0);
    obs_mv  = m_if.valid;
    obs_md  = m_if.data;
    obs_sr  = s_if.ready;
    obs_cnt = count;
    chk("s_ready", s_if.ready, exp_sr);
    chk("m_valid", m_if.valid, exp_mv);
    if (exp_mv) chk("m_data", m_if.data, outq[0]);
    chk("count", count, ramq.size() + infl + outq.size());
    push = sv && exp_sr;
    pop  = mr && exp_mv;
    obs_push = push;
    chk("ram_we_a", ram_we_a, push);
    issue = (ramq.size() != 0) && (int'(outq.size()) + infl - int'(pop) < 2);
    @(posedge clk);
    if (pop) void'(outq.pop_front());
    if (infl != 0) outq.push_back(infl_word);
    infl = 0;
    if (issue) begin
      infl_word = ramq.pop_front();
      infl = 1;
    end
    if (push) ramq.push_back(sd);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 64 && (ramq.size() + infl + outq.size()) != 0; i++)
      step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk(tag, obs_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = 8'h00;
    m_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_m_valid", m_if.valid, 0);
    chk("rst_s_ready", s_if.ready, 1);
    chk("rst_we_a", ram_we_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single word latency
    step(1'b1, 8'hA5, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("lat_c2_m_valid", obs_mv, 0);
    step(1'b0, 8'h00, 1'b1);
    chk("lat_c3_m_valid", obs_mv, 1);
    chk("lat_c3_m_data", obs_md, 8'hA5);
    step(1'b0, 8'h00, 1'b1);
    chk("lat_c4_count", obs_cnt, 0);

    // fill with consumer stalled
    for (int i = 0; i < 26; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("fill_count", obs_cnt, 18);
    chk("fill_s_ready", obs_sr, 0);
    chk("fill_m_valid", obs_mv, 1);
    chk("fill_m_data", obs_md, 8'h00);
    drain("fill_drain_count");

    // streaming
    nout = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 8'(i), 1'b1);
      if (i >= 3 && obs_mv) nout++;
    end
    chk("stream_rate", nout, 97);
    drain("stream_drain_count");

    // wrap rounds
    dcnt = 8'h40;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 24; i++) begin
        step(1'b1, dcnt, 1'b0);
        if (obs_push) dcnt = dcnt + 8'd1;
      end
      chk("wrap_full", obs_sr, 0);
      drain("wrap_drain_count");
    end

    // random backpressure
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    drain("rand_drain_count");

    // reset mid-stream with 5 words held
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0);
    chk("pre_rst_count", obs_cnt, 5);
    @(negedge clk);
    rst_n = 1'b0;
    s_if.valid = 1'b0;
    m_if.ready = 1'b0;
    #1;
    chk("mid_rst_m_valid", m_if.valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_s_ready", s_if.ready, 1);
    ramq.delete();
    outq.delete();
    infl = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h77, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);
    chk("post_rst_m_valid", obs_mv, 1);
    chk("post_rst_first", obs_md, 8'h77);
    drain("post_rst_drain_count");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
